// File: rtl/vga_pkg.sv
// Shared types and constants for the rectangle-fill DMA: FSM state encoding,
// pixel stride on the bus and the packed colour width helper.
package vga_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      REQ,
      GAP,
      DONE
   } state_t;

   localparam int PIXEL_STRIDE = 4;

   function automatic int color_width(input int depth);
      return 3 * depth;
   endfunction

endpackage

// File: rtl/vga_fill_addr_gen.sv
// Raster address stepper for the fill engine. It loads the first pixel address
// and the rectangle size, then walks it pixel by pixel using additions only.
module vga_fill_addr_gen
   import vga_pkg::*;
#(
   parameter int VGA_WIDTH = 640
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic [31:0] base_i,
   input  logic [15:0] w_i,
   input  logic [15:0] h_i,
   input  logic        step_i,
   output logic [31:0] addr_o,
   output logic        last_o
);

   localparam logic [31:0] ROW_STRIDE = 32'(PIXEL_STRIDE * VGA_WIDTH);

   logic [31:0] row_base_q, row_base_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] w_q, w_d;
   logic [15:0] col_q, col_d;
   logic [15:0] row_q, row_d;

   // col_q/row_q count the pixels remaining after the current one
   always_comb begin
      row_base_d = row_base_q;
      addr_d     = addr_q;
      w_d        = w_q;
      col_d      = col_q;
      row_d      = row_q;
      if (load_i) begin
         row_base_d = base_i;
         addr_d     = base_i;
         w_d        = w_i;
         col_d      = w_i - 16'd1;
         row_d      = h_i - 16'd1;
      end else if (step_i) begin
         if (col_q == 16'd0) begin
            row_base_d = row_base_q + ROW_STRIDE;
            addr_d     = row_base_q + ROW_STRIDE;
            col_d      = w_q - 16'd1;
            row_d      = row_q - 16'd1;
         end else begin
            addr_d = addr_q + 32'(PIXEL_STRIDE);
            col_d  = col_q - 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_base_q <= '0;
         addr_q     <= '0;
         w_q        <= '0;
         col_q      <= '0;
         row_q      <= '0;
      end else begin
         row_base_q <= row_base_d;
         addr_q     <= addr_d;
         w_q        <= w_d;
         col_q      <= col_d;
         row_q      <= row_d;
      end
   end

   assign addr_o = addr_q;
   assign last_o = (col_q == 16'd0) && (row_q == 16'd0);

endmodule

// File: rtl/vga_fill_dma.sv
// Rectangle fill DMA: writes a solid colour into a linear framebuffer, one
// handshaked bus write per pixel. Define VGA_FILL_CLIP_EN to clip to the screen.
//
//   state | meaning
//   IDLE  | waiting for start_i
//   SETUP | compute first address, reject or skip empty rectangles
//   REQ   | write_request_o held until response_i or timeout
//   GAP   | one idle bus cycle between writes
//   DONE  | done_o pulse, back to IDLE
module vga_fill_dma
   import vga_pkg::*;
#(
   parameter int          VGA_WIDTH       = 640,
   parameter int          VGA_HEIGHT      = 480,
   parameter int          VGA_COLOR_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int          TIMEOUT         = 255
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start_i,
   input  logic [15:0]                            x_i,
   input  logic [15:0]                            y_i,
   input  logic [15:0]                            w_i,
   input  logic [15:0]                            h_i,
   input  logic [color_width(VGA_COLOR_DEPTH)-1:0] color_i,
   output logic                                   busy_o,
   output logic                                   done_o,
   output logic                                   error_o,
   output logic [31:0]                            pixels_o,
   output logic                                   write_request_o,
   output logic                                   read_request_o,
   output logic [31:0]                            address_o,
   output logic [31:0]                            write_data_o,
   input  logic                                   response_i
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t        state_q;
   logic [15:0]   x_q, y_q, w_q, h_q;
   logic [31:0]   data_q;
   logic [31:0]   pixels_q;
   logic [TW-1:0] timer_q;
   logic          busy_q, done_q, error_q, wr_req_q, fin_q;

   logic [16:0]   x_end, y_end;
   logic [15:0]   w_eff, h_eff;
   logic          empty, reject;
   logic [31:0]   row_base;
   logic          gen_load, gen_step, gen_last;
   logic [31:0]   gen_addr;

   always_comb begin
      x_end  = {1'b0, x_q} + {1'b0, w_q};
      y_end  = {1'b0, y_q} + {1'b0, h_q};
      w_eff  = w_q;
      h_eff  = h_q;
      reject = 1'b0;
`ifdef VGA_FILL_CLIP_EN
      if ({1'b0, x_q} >= 17'(VGA_WIDTH))       w_eff = '0;
      else if (x_end > 17'(VGA_WIDTH))         w_eff = 16'(VGA_WIDTH) - x_q;
      if ({1'b0, y_q} >= 17'(VGA_HEIGHT))      h_eff = '0;
      else if (y_end > 17'(VGA_HEIGHT))        h_eff = 16'(VGA_HEIGHT) - y_q;
`else
      reject = (x_end > 17'(VGA_WIDTH)) || (y_end > 17'(VGA_HEIGHT));
`endif
      empty    = (w_eff == 16'd0) || (h_eff == 16'd0);
      row_base = BASE_ADDR + 32'(PIXEL_STRIDE) * (32'(y_q) * 32'(VGA_WIDTH) + 32'(x_q));
   end

   // The final pixel is not stepped so the generator never walks off the rectangle
   assign gen_load = (state_q == SETUP);
   assign gen_step = (state_q == REQ) && response_i && !gen_last;

   vga_fill_addr_gen #(
      .VGA_WIDTH (VGA_WIDTH)
   ) u_addr_gen (
      .clk    (clk),
      .rst    (rst),
      .load_i (gen_load),
      .base_i (row_base),
      .w_i    (w_eff),
      .h_i    (h_eff),
      .step_i (gen_step),
      .addr_o (gen_addr),
      .last_o (gen_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         w_q      <= '0;
         h_q      <= '0;
         data_q   <= '0;
         pixels_q <= '0;
         timer_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         wr_req_q <= 1'b0;
         fin_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  x_q      <= x_i;
                  y_q      <= y_i;
                  w_q      <= w_i;
                  h_q      <= h_i;
                  data_q   <= 32'(color_i);
                  error_q  <= 1'b0;
                  pixels_q <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               if (empty || reject) begin
                  error_q <= reject && !empty;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  wr_req_q <= 1'b1;
                  timer_q  <= TW'(TIMEOUT);
                  state_q  <= REQ;
               end
            end
            REQ: begin
               if (response_i) begin
                  wr_req_q <= 1'b0;
                  pixels_q <= pixels_q + 32'd1;
                  fin_q    <= gen_last;
                  state_q  <= GAP;
               end else if (timer_q == TW'(1)) begin
                  wr_req_q <= 1'b0;
                  error_q  <= 1'b1;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            GAP: begin
               if (fin_q) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  wr_req_q <= 1'b1;
                  timer_q  <= TW'(TIMEOUT);
                  state_q  <= REQ;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign error_o         = error_q;
   assign pixels_o        = pixels_q;
   assign write_request_o = wr_req_q;
   assign read_request_o  = 1'b0;
   assign address_o       = gen_addr;
   assign write_data_o    = data_q;

endmodule

// File: doc/vga_fill_dma.md
VGA_FILL_DMA -- requirements
Module: vga_fill_dma

Interface
REQ-001 Parameter VGA_WIDTH, default 640: framebuffer width in pixels.
REQ-002 Parameter VGA_HEIGHT, default 480: framebuffer height in pixels.
REQ-003 Parameter VGA_COLOR_DEPTH, default 8: bits per colour channel.
REQ-004 Parameter BASE_ADDR, default 32'h0000_0000: bus address of pixel (0,0).
REQ-005 Parameter TIMEOUT, default 255: maximum cycles to wait for response_i per write.
REQ-006 clk  in  1: single clock; all logic rising-edge.
REQ-007 rst  in  1: reset, asynchronous and active-high.
REQ-008 start_i  in  1: one-cycle fill command strobe.
REQ-009 x_i, y_i  in  16 each: rectangle top-left pixel.
REQ-010 w_i, h_i  in  16 each: rectangle width and height in pixels.
REQ-011 color_i  in  3*VGA_COLOR_DEPTH: fill colour, {R,G,B}.
REQ-012 busy_o  out  1: fill in progress.
REQ-013 done_o  out  1: one-cycle pulse at fill completion, including aborted or empty fills.
REQ-014 error_o  out  1: sticky fault flag, cleared by the next accepted start.
REQ-015 pixels_o  out  32: pixels acknowledged in the current or last fill.
REQ-016 write_request_o / read_request_o  out  1 each: bus initiator strobes; read_request_o is constant 0.
REQ-017 address_o, write_data_o  out  32 each: bus address and data; data is color zero-extended.
REQ-018 response_i  in  1: responder acknowledge.

Function
REQ-019 The FSM states SHALL be IDLE, SETUP, REQ, GAP, DONE.
REQ-020 In IDLE, start_i SHALL latch all command inputs, clear error_o and pixels_o, and move to SETUP; start_i outside IDLE is ignored.
REQ-021 SETUP SHALL take one cycle: compute row base = BASE_ADDR + 4*(y*VGA_WIDTH + x); if w==0 or h==0 (after clipping when enabled), go to DONE with zero writes.
REQ-022 In REQ, write_request_o SHALL be 1 with address_o/write_data_o stable until the cycle response_i==1 is sampled.
REQ-023 On acknowledge, pixels_o SHALL increment and the FSM go to GAP, where write_request_o is 0 for exactly one cycle.
REQ-024 Order SHALL be raster: address +4 per pixel; at end of row, address = previous row base + 4*VGA_WIDTH; no multiply after SETUP.
REQ-025 After the last pixel's GAP, the FSM SHALL enter DONE, pulse done_o for one cycle, and return to IDLE.
REQ-026 If response_i stays 0 for TIMEOUT consecutive cycles in REQ, the FSM SHALL drop the request, set error_o, and go to DONE.
REQ-027 response_i outside REQ SHALL be ignored.
REQ-028 busy_o SHALL be 1 in SETUP, REQ, and GAP.

Reset
REQ-029 Asserting rst at any time, including mid-request, SHALL immediately force IDLE and drive all outputs to 0.

Configuration
REQ-030 With VGA_FILL_CLIP_EN defined, the rectangle SHALL be clipped to [0,VGA_WIDTH)x[0,VGA_HEIGHT); a fully off-screen rectangle yields zero writes and no error.
REQ-031 Without VGA_FILL_CLIP_EN, any rectangle extending past the screen SHALL be rejected in SETUP: error_o=1, zero writes, done_o pulsed.

Structure
REQ-032 vga_pkg SHALL hold the FSM state enum, PIXEL_STRIDE=4, and the colour width function.
REQ-033 Address stepping SHALL live in the sub-module vga_fill_addr_gen; the rest stays in vga_fill_dma.

Verification
REQ-034 Fill x=0,y=0,w=2,h=2, responder acks 1 cycle after request -> addresses 0x0,0x4,0xA00,0xA04; pixels_o=4; one done_o pulse.
REQ-035 w=0 -> done_o 2 cycles after start; no write_request_o; error_o=0.
REQ-036 Responder never acks, TIMEOUT=255 -> request drops after 255 cycles; error_o=1; pixels_o=0; done_o pulsed.
REQ-037 x=638,w=4,h=1: with VGA_FILL_CLIP_EN -> 2 writes (0x9F8,0x9FC); without it -> error_o=1 and 0 writes.
REQ-038 rst asserted during REQ of the 3rd pixel -> write_request_o=0 the same cycle; busy_o=0; a subsequent start runs normally.
REQ-039 start_i pulsed while busy -> ignored; latched command and pixel count unchanged.
